// File: rtl/mux4_1_wide_reg.sv
// WIDTH-wide 4:1 selector built as a two-level tree of 2:1 wide muxes.
// Provides a zero-latency combinational result and an enable-gated registered copy.

module mux2_wide #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in [0:1],
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Bit-for-bit select; no reordering, so bit i of out always comes from bit i of an input.
  assign out = sel ? in[1] : in[0];

endmodule

module mux4_1_wide_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in [0:3],
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] mux_a_in [0:1];
  logic [WIDTH-1:0] mux_b_in [0:1];
  logic [WIDTH-1:0] mux_c_in [0:1];
  logic [WIDTH-1:0] mux_a_out;
  logic [WIDTH-1:0] mux_b_out;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] cap_q;

  assign mux_a_in[0] = in[0];
  assign mux_a_in[1] = in[1];
  assign mux_b_in[0] = in[2];
  assign mux_b_in[1] = in[3];

  // Level 1: low select bit picks within each pair.
  mux2_wide #(.WIDTH(WIDTH)) u_mux_a (
    .in  (mux_a_in),
    .sel (sel[0]),
    .out (mux_a_out)
  );

  mux2_wide #(.WIDTH(WIDTH)) u_mux_b (
    .in  (mux_b_in),
    .sel (sel[0]),
    .out (mux_b_out)
  );

  assign mux_c_in[0] = mux_a_out;
  assign mux_c_in[1] = mux_b_out;

  // Level 2: high select bit picks between the pairs.
  mux2_wide #(.WIDTH(WIDTH)) u_mux_c (
    .in  (mux_c_in),
    .sel (sel[1]),
    .out (out)
  );

  assign cap_d = en ? out : cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign out_q = cap_q;

endmodule

// File: tb/tb_mux4_1_wide_reg.sv
// Randomized scoreboard bench for mux4_1_wide_reg at WIDTH 64, 8 and 1.

module tb_mux4_1_wide_reg;

  localparam int EW = 64 + 64 + 8 + 8 + 1 + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b0;

  // driven stimulus
  logic [63:0] a64 [0:3];
  logic [7:0]  a8  [0:3];
  logic        a1  [0:3];
  logic [1:0]  s64, s8, s1;

  // next stimulus staged by the sequence
  logic [63:0] n64 [0:3];
  logic [7:0]  n8  [0:3];
  logic        n1  [0:3];
  logic [1:0]  ns64, ns8, ns1;

  logic [63:0] o64, q64;
  logic [7:0]  o8, q8;
  logic        o1, q1;

  // reference register contents
  logic [63:0] m64;
  logic [7:0]  m8;
  logic        m1;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mux4_1_wide_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in(a64), .sel(s64), .en(en), .out(o64), .out_q(q64)
  );
  mux4_1_wide_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(a8), .sel(s8), .en(en), .out(o8), .out_q(q8)
  );
  mux4_1_wide_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(a1), .sel(s1), .en(en), .out(o1), .out_q(q1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_next();
    for (int i = 0; i < 4; i++) begin
      n64[i] = {$urandom, $urandom};
      n8[i]  = 8'($urandom_range(0, 255));
      n1[i]  = 1'($urandom_range(0, 1));
    end
    ns64 = 2'($urandom_range(0, 3));
    ns8  = 2'($urandom_range(0, 3));
    ns1  = 2'($urandom_range(0, 3));
  endtask

  // One clock of stimulus: advance the reference register over the edge,
  // then apply staged inputs dly time units after it and queue the expectation.
  task automatic apply(input logic rst, input logic e, input int dly);
    @(posedge clk);
    if (rst_n && en) begin
      m64 = a64[s64];
      m8  = a8[s8];
      m1  = a1[s1];
    end
    #(dly);
    a64 = n64; a8 = n8; a1 = n1;
    s64 = ns64; s8 = ns8; s1 = ns1;
    rst_n = rst;
    en    = e;
    if (!rst) begin
      m64 = '0; m8 = '0; m1 = 1'b0;
    end
    exp_q.push_back({a64[s64], m64, a8[s8], m8, a1[s1], m1});
  endtask

  // monitor: outputs are stable at the falling edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out64",   o64,          e[145:82]);
        check("out_q64", q64,          e[81:18]);
        check("out8",    {56'd0, o8},  {56'd0, e[17:10]});
        check("out_q8",  {56'd0, q8},  {56'd0, e[9:2]});
        check("out1",    {63'd0, o1},  {63'd0, e[1]});
        check("out_q1",  {63'd0, q1},  {63'd0, e[0]});
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 4; i++) begin
      a64[i] = '0; a8[i] = '0; a1[i] = 1'b0;
    end
    s64 = '0; s8 = '0; s1 = '0;
    m64 = '0; m8 = '0; m1 = 1'b0;

    // reset held with clock running and en high
    rand_next();
    n64[2] = 64'hAAAA5555AAAA5555; ns64 = 2'd2;
    apply(1'b0, 1'b1, 1);
    apply(1'b0, 1'b1, 1);
    apply(1'b0, 1'b1, 1);

    // release, capture, then hold with en low
    rand_next();
    n64[1] = 64'h1122334455667788; ns64 = 2'd1;
    apply(1'b1, 1'b1, 1);
    n64[3] = 64'h0000000000000099; ns64 = 2'd3;
    apply(1'b1, 1'b0, 1);
    apply(1'b1, 1'b0, 1);

    // async reset between edges while out_q holds a nonzero word
    apply(1'b0, 1'b0, 3);
    apply(1'b0, 1'b1, 1);
    apply(1'b1, 1'b1, 1);

    // directed sel sweep
    rand_next();
    n64[0] = 64'h0123456789ABCDEF;
    n64[1] = 64'hFEDCBA9876543210;
    n64[2] = 64'hFFFFFFFFFFFFFFFF;
    n64[3] = 64'h0000000000000000;
    for (int k = 0; k < 4; k++) begin
      ns64 = 2'(k);
      apply(1'b1, 1'b1, 1);
    end

    // random words, round-robin sel, exhaustive WIDTH=1 patterns in the first 64
    for (int i = 0; i < 128; i++) begin
      logic [5:0] idx;
      rand_next();
      ns64 = 2'(i % 4);
      if (i < 64) begin
        idx = 6'(i);
        for (int b = 0; b < 4; b++) n1[b] = idx[b];
        ns1 = idx[5:4];
      end
      apply(1'b1, 1'($urandom_range(0, 1)), 1);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_1_wide_reg.md
Name: mux4_1_wide_reg

Overview:
- Parametrized-width 4:1 multiplexer used as a building block for wider selectors (8:1 trees, register-file read ports, forwarding muxes) in the pipelined CPU.
- Built structurally from a 2:1 wide-mux primitive.
- Provides a zero-latency combinational output and an optionally registered copy of the selected word for use as a pipeline-stage boundary.

Parameters:
- WIDTH, default 64, bit width of every data input and of both outputs (legal range WIDTH >= 1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset; clears the registered output only.
- in  input  WIDTH x 4 (unpacked array, index 0..3)  the four candidate data words.
- sel  input  2  selector; sel = k chooses in[k].
- en  input  1  load enable for the output register.
- out  output  WIDTH  combinational result, in[sel].
- out_q  output  WIDTH  registered result.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Structure is fixed as a two-level tree of WIDTH-wide 2:1 multiplexers:
  - Level 1: mux A selects in[0]/in[1] on sel[0]; mux B selects in[2]/in[3] on sel[0].
  - Level 2: selects A/B on sel[1] (sel[1]=0 -> A).
- The 2:1 primitive has ports out, in[0:1], sel, with out = in[sel], per-bit, no bit reordering.
- out = in[sel] for all four sel values, bit-exact across all WIDTH bits, including all-ones and all-zeros words.
- out has zero clock latency: purely combinational, with no dependence on clk, rst_n or en.
- Any change on in or sel propagates to out within the combinational delay budget of two 2:1 stages.
- out_q register:
  - rst_n low: out_q = 0 immediately, independent of clk; held at 0 while rst_n stays low.
  - rst_n high, rising clk, en = 1: out_q <= in[sel] as sampled at that edge (one-cycle latency from out to out_q).
  - rst_n high, rising clk, en = 0: out_q holds its value.
  - rst_n deasserted: the first capture occurs on the first rising clk edge with en = 1 after deassertion.
  - rst_n asserted mid-operation: out_q clears at once; no pending capture survives.
- Simultaneous sel/in change and clk edge: the register captures the pre-edge values; no combinational path from out_q back to out.
- sel containing X/Z: out is don't-care.
- No internal state other than the out_q register; no width truncation or extension anywhere.

Test Plan:
- WIDTH=64, rst_n=1, in = {0x0123456789ABCDEF, 0xFEDCBA9876543210, 0xFFFFFFFFFFFFFFFF, 0x0000000000000000}, sweep sel 0..3 -> out equals in[0], in[1], in[2], in[3] respectively, checked after settle delay.
- 128 iterations: fresh random 64-bit values on all four inputs each iteration, sel incremented round-robin (wrapping 3 -> 0) -> out == in[sel] every iteration.
- rst_n=0 with en=1, sel=2, in[2]=0xAAAA5555AAAA5555, clock running -> out_q = 0 throughout, while out = 0xAAAA5555AAAA5555.
- Release rst_n, en=1, sel=1, in[1]=0x1122334455667788 -> out_q = 0x1122334455667788 after the first rising edge. Then set en=0, change sel to 3 with in[3]=0x99 -> out_q stays 0x1122334455667788 while out = 0x99.
- Assert rst_n asynchronously between clock edges while out_q is nonzero -> out_q = 0 before the next edge.
- WIDTH=1 and WIDTH=8 instances: exhaustive sel and input patterns for WIDTH=1 (64 combinations) -> out == in[sel] in all cases.
